// File: rtl/mem_wb_stage.sv
// MIPS-Lite writeback stage: MEM/WB register, architectural register file with
// write-first bypass, forwarding source for execute, retire counters and HALT control.
module mem_wb_stage #(
    parameter int unsigned DATA        = 32,
    parameter int unsigned REG_COUNT   = 32,
    parameter int unsigned COUNT_WIDTH = 32,
    localparam int unsigned AW         = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [31:0]            in_instr,
    input  logic [DATA-1:0]        in_alu_data,
    input  logic [DATA-1:0]        in_mem_data,
    output logic                   in_ready,
    input  logic [AW-1:0]          rd_addr_a,
    input  logic [AW-1:0]          rd_addr_b,
    output logic [DATA-1:0]        rd_data_a,
    output logic [DATA-1:0]        rd_data_b,
    output logic                   fwd_valid,
    output logic [AW-1:0]          fwd_reg,
    output logic [DATA-1:0]        fwd_data,
    output logic                   halted,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] cnt_total,
    output logic [COUNT_WIDTH-1:0] cnt_arith,
    output logic [COUNT_WIDTH-1:0] cnt_logic,
    output logic [COUNT_WIDTH-1:0] cnt_mem,
    output logic [COUNT_WIDTH-1:0] cnt_ctrl
);

    localparam logic [5:0] OP_LOGIC_LO = 6'd6;
    localparam logic [5:0] OP_LAST_ALU = 6'd11;
    localparam logic [5:0] OP_LDW      = 6'd12;
    localparam logic [5:0] OP_STW      = 6'd13;
    localparam logic [5:0] OP_BZ       = 6'd14;
    localparam logic [5:0] OP_HALT     = 6'd17;

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_e;

    state_e state_q;

    // MEM/WB pipeline register (only the instruction fields writeback needs)
    logic            wb_valid_q, wb_valid_d;
    logic [5:0]      wb_op_q;
    logic [4:0]      wb_rt_q;
    logic [4:0]      wb_rd_q;
    logic [DATA-1:0] wb_alu_q;
    logic [DATA-1:0] wb_mem_q;

    logic [DATA-1:0] regs_q [REG_COUNT];

    logic [COUNT_WIDTH-1:0] cnt_total_q, cnt_arith_q, cnt_logic_q, cnt_mem_q, cnt_ctrl_q;

    logic            dec_writes;
    logic            dec_is_ldw;
    logic [AW-1:0]   dec_dest;
    logic            cat_arith, cat_logic, cat_mem, cat_ctrl, cat_illegal;
    logic            halt_retire;
    logic            capture_en;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{in_instr[25:21], in_instr[10:0]};

    // Opcodes 0-11 alternate R-type (even, dest=rd) and immediate (odd, dest=rt)
    always_comb begin
        dec_writes  = 1'b0;
        dec_is_ldw  = 1'b0;
        dec_dest    = '0;
        cat_arith   = 1'b0;
        cat_logic   = 1'b0;
        cat_mem     = 1'b0;
        cat_ctrl    = 1'b0;
        cat_illegal = 1'b0;
        if (wb_op_q <= OP_LAST_ALU) begin
            dec_writes = 1'b1;
            dec_dest   = wb_op_q[0] ? AW'(wb_rt_q) : AW'(wb_rd_q);
            if (wb_op_q < OP_LOGIC_LO) begin
                cat_arith = 1'b1;
            end else begin
                cat_logic = 1'b1;
            end
        end else if (wb_op_q == OP_LDW) begin
            dec_writes = 1'b1;
            dec_is_ldw = 1'b1;
            dec_dest   = AW'(wb_rt_q);
            cat_mem    = 1'b1;
        end else if (wb_op_q == OP_STW) begin
            cat_mem = 1'b1;
        end else if (wb_op_q >= OP_BZ && wb_op_q <= OP_HALT) begin
            cat_ctrl = 1'b1;
        end else begin
            cat_illegal = 1'b1;
        end
    end

    assign fwd_valid = wb_valid_q && dec_writes && (dec_dest != '0);
    assign fwd_reg   = dec_dest;
    assign fwd_data  = dec_is_ldw ? wb_mem_q : wb_alu_q;

    // A retiring HALT blocks the instruction presented alongside it
    assign halt_retire = wb_valid_q && (wb_op_q == OP_HALT);
    assign capture_en  = in_valid && (state_q == S_RUN) && !halt_retire;
    assign wb_valid_d  = capture_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            halted   <= 1'b0;
            in_ready <= 1'b1;
            illegal  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (halt_retire) begin
                        state_q  <= S_HALTED;
                        halted   <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                S_HALTED: begin
                    state_q  <= S_HALTED;
                    halted   <= 1'b1;
                    in_ready <= 1'b0;
                end
                default: begin
                    state_q  <= S_RUN;
                    halted   <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
            if (wb_valid_q && cat_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_op_q    <= '0;
            wb_rt_q    <= '0;
            wb_rd_q    <= '0;
            wb_alu_q   <= '0;
            wb_mem_q   <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            if (capture_en) begin
                wb_op_q  <= in_instr[31:26];
                wb_rt_q  <= in_instr[20:16];
                wb_rd_q  <= in_instr[15:11];
                wb_alu_q <= in_alu_data;
                wb_mem_q <= in_mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (fwd_valid) begin
            regs_q[fwd_reg] <= fwd_data;
        end
    end

    // R0 reads as zero; a same-cycle write to the addressed register is bypassed
    assign rd_data_a = (rd_addr_a == '0) ? '0 :
                       (fwd_valid && (rd_addr_a == fwd_reg)) ? fwd_data : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 :
                       (fwd_valid && (rd_addr_b == fwd_reg)) ? fwd_data : regs_q[rd_addr_b];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_total_q <= '0;
            cnt_arith_q <= '0;
            cnt_logic_q <= '0;
            cnt_mem_q   <= '0;
            cnt_ctrl_q  <= '0;
        end else if (wb_valid_q) begin
            cnt_total_q <= cnt_total_q + COUNT_WIDTH'(1);
            if (cat_arith) cnt_arith_q <= cnt_arith_q + COUNT_WIDTH'(1);
            if (cat_logic) cnt_logic_q <= cnt_logic_q + COUNT_WIDTH'(1);
            if (cat_mem)   cnt_mem_q   <= cnt_mem_q + COUNT_WIDTH'(1);
            if (cat_ctrl)  cnt_ctrl_q  <= cnt_ctrl_q + COUNT_WIDTH'(1);
        end
    end

    assign cnt_total = cnt_total_q;
    assign cnt_arith = cnt_arith_q;
    assign cnt_logic = cnt_logic_q;
    assign cnt_mem   = cnt_mem_q;
    assign cnt_ctrl  = cnt_ctrl_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: forwarding expectations queued at issue,
// popped one cycle later; register file, counters and HALT checked directly.
module tb_mem_wb_stage;

    localparam int unsigned DATA = 32;
    localparam int unsigned CW   = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [31:0]     in_instr = '0;
    logic [DATA-1:0] in_alu_data = '0;
    logic [DATA-1:0] in_mem_data = '0;
    logic            in_ready;
    logic [4:0]      rd_addr_a = '0;
    logic [4:0]      rd_addr_b = '0;
    logic [DATA-1:0] rd_data_a, rd_data_b;
    logic            fwd_valid;
    logic [4:0]      fwd_reg;
    logic [DATA-1:0] fwd_data;
    logic            halted, illegal;
    logic [CW-1:0]   cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_ctrl;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_alu_data(in_alu_data), .in_mem_data(in_mem_data), .in_ready(in_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .halted(halted), .illegal(illegal),
        .cnt_total(cnt_total), .cnt_arith(cnt_arith), .cnt_logic(cnt_logic),
        .cnt_mem(cnt_mem), .cnt_ctrl(cnt_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;
    logic mon_en  = 1'b0;
    logic exp_cap = 1'b0;
    logic mon_due = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        return {op, 5'd1, rt, rd, 11'd0};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] mem,
                       input logic ev, input logic [4:0] er, input logic [31:0] ed);
        exp_t e;
        in_valid    = 1'b1;
        exp_cap     = 1'b1;
        in_instr    = instr;
        in_alu_data = alu;
        in_mem_data = mem;
        e.v = ev; e.r = er; e.d = ed;
        sb.push_back(e);
        nxt();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        exp_cap  = 1'b0;
    endtask

    // Instruction captured at a posedge must show its forwarding view during the next cycle
    always @(posedge clk) mon_due <= in_valid && exp_cap;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mon_due) begin
                chk("sb_size", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("fwd_valid", 32'(fwd_valid), 32'(e.v));
                    if (e.v) begin
                        chk("fwd_reg", 32'(fwd_reg), 32'(e.r));
                        chk("fwd_data", fwd_data, e.d);
                    end
                end
            end else begin
                chk("fwd_idle", 32'(fwd_valid), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) nxt();
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_total", cnt_total, 32'd0);

        // ADDI r5
        nxt();
        put(mk(6'd1, 5'd5, 5'd0), 32'h10, 32'h0, 1'b1, 5'd5, 32'h10);
        idle();
        rd_addr_a = 5'd5;
        @(negedge clk);
        chk("addi_bypass", rd_data_a, 32'h10);
        chk("addi_arith_pre", cnt_arith, 32'd0);
        nxt();
        @(negedge clk);
        chk("addi_r5", rd_data_a, 32'h10);
        chk("addi_arith", cnt_arith, 32'd1);
        chk("addi_total", cnt_total, 32'd1);

        // LDW r3 selects load data, then STW leaves r3 alone
        nxt();
        put(mk(6'd12, 5'd3, 5'd0), 32'hDEAD, 32'h1234_5678, 1'b1, 5'd3, 32'h1234_5678);
        idle();
        rd_addr_b = 5'd3;
        @(negedge clk);
        chk("ldw_bypass", rd_data_b, 32'h1234_5678);
        nxt();
        @(negedge clk);
        chk("ldw_r3", rd_data_b, 32'h1234_5678);
        chk("ldw_mem", cnt_mem, 32'd1);
        nxt();
        put(mk(6'd13, 5'd3, 5'd0), 32'h99, 32'h0, 1'b0, 5'd0, 32'h0);
        idle();
        nxt();
        @(negedge clk);
        chk("stw_r3", rd_data_b, 32'h1234_5678);
        chk("stw_mem", cnt_mem, 32'd2);

        // ADD to r0 is dropped
        nxt();
        put(mk(6'd0, 5'd2, 5'd0), 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 32'h0);
        idle();
        rd_addr_a = 5'd0;
        @(negedge clk);
        chk("r0_wb", rd_data_a, 32'h0);
        nxt();
        @(negedge clk);
        chk("r0_after", rd_data_a, 32'h0);
        chk("r0_arith", cnt_arith, 32'd2);

        // Back-to-back logic ops on r7
        nxt();
        put(mk(6'd10, 5'd9, 5'd7), 32'd1, 32'h0, 1'b1, 5'd7, 32'd1);
        put(mk(6'd6, 5'd9, 5'd7), 32'd2, 32'h0, 1'b1, 5'd7, 32'd2);
        put(mk(6'd8, 5'd9, 5'd7), 32'd3, 32'h0, 1'b1, 5'd7, 32'd3);
        idle();
        rd_addr_a = 5'd7;
        @(negedge clk);
        chk("r7_bypass", rd_data_a, 32'd3);
        nxt();
        @(negedge clk);
        chk("r7_final", rd_data_a, 32'd3);
        chk("logic_cnt", cnt_logic, 32'd3);

        // Undefined opcode
        nxt();
        put(mk(6'h3F, 5'd4, 5'd4), 32'h5, 32'h0, 1'b0, 5'd0, 32'h0);
        idle();
        @(negedge clk);
        chk("illegal_pre", 32'(illegal), 32'd0);
        nxt();
        @(negedge clk);
        chk("illegal_set", 32'(illegal), 32'd1);
        chk("illegal_total", cnt_total, 32'd8);
        chk("illegal_arith", cnt_arith, 32'd2);
        chk("illegal_logic", cnt_logic, 32'd3);
        chk("illegal_mem", cnt_mem, 32'd2);
        chk("illegal_ctrl", cnt_ctrl, 32'd0);

        // HALT with ADDI r1 presented at the retiring edge
        nxt();
        put(mk(6'd17, 5'd0, 5'd0), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_cap     = 1'b0;
        in_valid    = 1'b1;
        in_instr    = mk(6'd1, 5'd1, 5'd0);
        in_alu_data = 32'h55;
        rd_addr_a   = 5'd1;
        @(negedge clk);
        chk("halt_ready_pre", 32'(in_ready), 32'd1);
        chk("halt_flag_pre", 32'(halted), 32'd0);
        nxt();
        @(negedge clk);
        chk("halted", 32'(halted), 32'd1);
        chk("halt_ready", 32'(in_ready), 32'd0);
        chk("halt_ctrl", cnt_ctrl, 32'd1);
        chk("halt_total", cnt_total, 32'd9);
        chk("halt_r1", rd_data_a, 32'h0);
        repeat (10) nxt();
        @(negedge clk);
        chk("frozen_total", cnt_total, 32'd9);
        chk("frozen_ctrl", cnt_ctrl, 32'd1);
        chk("frozen_arith", cnt_arith, 32'd2);
        chk("frozen_r1", rd_data_a, 32'h0);
        chk("frozen_r3", rd_data_b, 32'h1234_5678);
        chk("frozen_halted", 32'(halted), 32'd1);
        chk("illegal_sticky", 32'(illegal), 32'd1);

        // Reset clears the halt and all state
        idle();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        rd_addr_a = 5'd5;
        @(negedge clk);
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_ready", 32'(in_ready), 32'd1);
        chk("rst2_illegal", 32'(illegal), 32'd0);
        chk("rst2_total", cnt_total, 32'd0);
        chk("rst2_ctrl", cnt_ctrl, 32'd0);
        chk("rst2_r5", rd_data_a, 32'h0);
        chk("rst2_r3", rd_data_b, 32'h0);

        // Capture resumes after reset
        nxt();
        put(mk(6'd1, 5'd1, 5'd0), 32'h77, 32'h0, 1'b1, 5'd1, 32'h77);
        idle();
        rd_addr_a = 5'd1;
        nxt();
        @(negedge clk);
        chk("resume_r1", rd_data_a, 32'h77);
        chk("resume_total", cnt_total, 32'd1);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Writeback stage of the MIPS-Lite 5-stage pipeline, directly downstream of the memory-access stage.
- Registers the MEM/WB boundary (instruction word, ALU result, load data) and selects the writeback value.
- Owns the architectural register file (two combinational read ports for decode, write-first bypass) and drives the forwarding source for execute.
- Keeps retire statistics and stops the pipeline on HALT.

Parameters:
DATA, 32, datapath and register width
REG_COUNT, 32, number of architectural registers (index width = clog2(REG_COUNT))
COUNT_WIDTH, 32, width of each statistics counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
in_valid  in  1  memory stage presents a retiring instruction this cycle
in_instr  in  32  instruction word (opcode[31:26], rs[25:21], rt[20:16], rd[15:11])
in_alu_data  in  DATA  ALU result passed through the memory stage
in_mem_data  in  DATA  load data from the memory stage
in_ready  out  1  0 once halted; upstream must hold off
rd_addr_a / rd_addr_b  in  5  decode read indices
rd_data_a / rd_data_b  out  DATA  read data
fwd_valid  out  1  WB register holds a register-writing instruction with dest != 0
fwd_reg  out  5  dest index of the WB instruction
fwd_data  out  DATA  value being written this cycle
halted  out  1  HALT has retired
illegal  out  1  sticky: an undefined opcode retired
cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_ctrl  out  COUNT_WIDTH  retire counters

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - WB register valid=0; all registers = 0; all counters = 0.
  - halted=0, illegal=0, in_ready=1.
  - State machine to RUN. Reset overrides everything, including a halt in progress.
- Capture: at a posedge with in_valid=1 and state RUN, latch in_instr, in_alu_data and in_mem_data into the WB register and set wb_valid=1. Otherwise wb_valid=0.
- Decode of the WB instruction:
  - R-type ADD(0), SUB(2), MUL(4), OR(6), AND(8), XOR(10): dest = rd.
  - Immediate forms ADDI(1), SUBI(3), MULI(5), ORI(7), ANDI(9), XORI(11), and LDW(12): dest = rt.
  - STW(13), BZ(14), BEQ(15), JR(16), HALT(17): no register write.
  - Opcodes 18-63: undefined; no write.
- Writeback value: in_mem_data for LDW, in_alu_data for all others.
- Register write timing: at the posedge that ends the cycle in which wb_valid=1. Latency is one cycle from capture to writeback, two edges from presentation to a visible register update.
- R0 is hardwired to 0. A write with dest=0 is dropped, and fwd_valid=0 for it.
- Reads are combinational. Index 0 returns 0. If the index equals a dest being written this cycle, the read returns fwd_data (write-first bypass). Both ports bypass independently.
- fwd_valid, fwd_reg and fwd_data are driven combinationally from the WB register. fwd_valid=0 when wb_valid=0.
- Counters (retire = wb_valid=1), each wrapping mod 2^COUNT_WIDTH:
  - cnt_total: +1 for every retired instruction, including undefined opcodes.
  - cnt_arith: opcodes 0-5.
  - cnt_logic: opcodes 6-11.
  - cnt_mem: opcodes 12-13.
  - cnt_ctrl: opcodes 14-17.
  - Undefined opcodes also set illegal, which stays 1 until rst.
- State machine:
  - RUN: normal operation.
  - RUN -> HALTED at the edge where a HALT retires. The HALT is itself counted.
  - HALTED: in_ready=0, halted=1, in_valid ignored (no capture), counters and registers frozen, read ports still functional. Exits only via rst.
- Simultaneous events: when HALT retires and in_valid=1 at the same edge, the presented instruction is not captured.

Test Plan:
- Reset, then ADDI r5 (alu_data=0x0000_0010) -> r5 reads 0x10 two edges after presentation. During the WB cycle: fwd_valid=1, fwd_reg=5, and rd_data_a with rd_addr_a=5 returns 0x10 via bypass. cnt_arith=1, cnt_total=1.
- LDW to r3 with alu_data=0xDEAD, mem_data=0x1234_5678 -> r3=0x1234_5678. cnt_mem=1. Then STW -> no register change, cnt_mem=2.
- ADD with rd=0, alu_data=0xFFFF_FFFF -> r0 reads 0 and fwd_valid=0. cnt_arith still increments.
- Back-to-back XOR r7, OR r7, AND r7 (alu 1, 2, 3) -> r7 ends at 3, cnt_logic=3, fwd_data follows 1, 2, 3 on consecutive cycles.
- Opcode 0x3F retires -> illegal=1, cnt_total+1, no category counter changes. illegal stays 1 until rst.
- HALT retires with in_valid held at 1 carrying ADDI r1 -> halted=1 and in_ready=0 next cycle. r1 unchanged, cnt_ctrl=1, counters frozen for 10 more cycles. rst then clears halted, counters and registers.
